// File: rtl/pid_wr_sequencer_if.sv
// Command handshake and channel write bus between the host-side sequencer and its users.
// master = host side (issues commands, observes the write bus); slave = the sequencer.
interface pid_wr_sequencer_if #(
    parameter int W_WR_ADDR = 16,
    parameter int W_WR_CHAN = 16,
    parameter int W_WR_DATA = 48
) ();
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [W_WR_ADDR-1:0] cmd_addr;
    logic [W_WR_CHAN-1:0] cmd_chan;
    logic [W_WR_DATA-1:0] cmd_data;

    logic                 wr_en;
    logic [W_WR_ADDR-1:0] wr_addr;
    logic [W_WR_CHAN-1:0] wr_chan;
    logic [W_WR_DATA-1:0] wr_data;

    logic                 busy;

    modport master (
        output cmd_valid, cmd_addr, cmd_chan, cmd_data,
        input  cmd_ready, wr_en, wr_addr, wr_chan, wr_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_chan, cmd_data,
        output cmd_ready, wr_en, wr_addr, wr_chan, wr_data, busy
    );
endinterface

// File: rtl/pid_wr_sequencer.sv
// Buffers host parameter writes in a small FIFO and replays them on the channel write bus,
// expanding broadcast-channel commands into one write per channel.
module pid_wr_sequencer #(
    parameter int W_WR_ADDR  = 16,
    parameter int W_WR_CHAN  = 16,
    parameter int W_WR_DATA  = 48,
    parameter int N_CHAN     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    pid_wr_sequencer_if.slave    bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = W_WR_ADDR + W_WR_CHAN + W_WR_DATA;

    localparam logic [CNT_W-1:0]     FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [W_WR_CHAN-1:0] LAST_CHAN  = W_WR_CHAN'(N_CHAN - 1);
    localparam logic [W_WR_CHAN-1:0] BCAST_CHAN = {W_WR_CHAN{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BCAST = 1'b1
    } state_t;

    logic [ENT_W-1:0]     mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;

    state_t               state_r;
    logic [W_WR_CHAN-1:0] cnt_r;
    logic                 wr_en_r;
    logic [W_WR_ADDR-1:0] wr_addr_r;
    logic [W_WR_CHAN-1:0] wr_chan_r;
    logic [W_WR_DATA-1:0] wr_data_r;

    logic                 full_s;
    logic                 empty_s;
    logic                 push_s;
    logic                 pop_s;
    logic [W_WR_ADDR-1:0] head_addr_s;
    logic [W_WR_CHAN-1:0] head_chan_s;
    logic [W_WR_DATA-1:0] head_data_s;

    assign full_s  = (count_r == FULL_COUNT);
    assign empty_s = (count_r == {CNT_W{1'b0}});
    // Ready looks only at occupancy, so a pop in the same cycle never lets a push into a full FIFO.
    assign push_s  = bus.cmd_valid && bus.cmd_ready;
    assign pop_s   = (state_r == ST_IDLE) && !empty_s;

    assign {head_addr_s, head_chan_s, head_data_s} = mem_r[rd_ptr_r];

    assign bus.cmd_ready = !full_s && !rst_in;
    assign bus.busy      = !empty_s || (state_r == ST_BCAST) || wr_en_r;
    assign bus.wr_en     = wr_en_r;
    assign bus.wr_addr   = wr_addr_r;
    assign bus.wr_chan   = wr_chan_r;
    assign bus.wr_data   = wr_data_r;

    // FIFO storage; contents need no reset since the count gates every read.
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {bus.cmd_addr, bus.cmd_chan, bus.cmd_data};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Issue FSM with registered write-bus outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {W_WR_CHAN{1'b0}};
            wr_en_r   <= 1'b0;
            wr_addr_r <= {W_WR_ADDR{1'b0}};
            wr_chan_r <= {W_WR_CHAN{1'b0}};
            wr_data_r <= {W_WR_DATA{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!empty_s) begin
                        wr_en_r   <= 1'b1;
                        wr_addr_r <= head_addr_s;
                        wr_data_r <= head_data_s;
                        if (head_chan_s == BCAST_CHAN) begin
                            wr_chan_r <= {W_WR_CHAN{1'b0}};
                            cnt_r     <= W_WR_CHAN'(1);
                            state_r   <= (N_CHAN > 1) ? ST_BCAST : ST_IDLE;
                        end else begin
                            wr_chan_r <= head_chan_s;
                            state_r   <= ST_IDLE;
                        end
                    end else begin
                        wr_en_r <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_BCAST: begin
                    // Address and data stay as loaded from the popped broadcast command.
                    wr_en_r   <= 1'b1;
                    wr_chan_r <= cnt_r;
                    cnt_r     <= cnt_r + W_WR_CHAN'(1);
                    if (cnt_r == LAST_CHAN) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_BCAST;
                    end
                end
                default: begin
                    wr_en_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pid_wr_sequencer.sv
// Directed bench: cycle-exact vector table for reset/single/back-to-back traffic,
// then hand-written broadcast, backpressure and reset-abort sequences checked from a write log.
module tb_pid_wr_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pid_wr_sequencer_if #(.W_WR_ADDR(16), .W_WR_CHAN(16), .W_WR_DATA(48)) bus_if ();

    pid_wr_sequencer #(
        .W_WR_ADDR(16), .W_WR_CHAN(16), .W_WR_DATA(48), .N_CHAN(8), .FIFO_DEPTH(4)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus(bus_if)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [15:0] addr;
        logic [15:0] chan;
        logic [47:0] data;
        logic        e_ready;
        logic        e_en;
        logic [15:0] e_addr;
        logic [15:0] e_chan;
        logic [47:0] e_data;
        logic        e_busy;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] chan;
        logic [47:0] data;
        int          cyc;
    } wr_t;

    wr_t log_q[$];
    int  cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_if.wr_en === 1'b1) begin
            log_q.push_back('{bus_if.wr_addr, bus_if.wr_chan, bus_if.wr_data, cyc});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic [15:0] a,
                                input logic [15:0] c, input logic [47:0] d,
                                input logic er, input logic ee, input logic [15:0] ea,
                                input logic [15:0] ec, input logic [47:0] ed, input logic eb);
        vec_t t;
        t.rst = r; t.valid = v; t.addr = a; t.chan = c; t.data = d;
        t.e_ready = er; t.e_en = ee; t.e_addr = ea; t.e_chan = ec; t.e_data = ed; t.e_busy = eb;
        return t;
    endfunction

    // Holds cmd_valid until accepted; returns on the negedge after the accepting edge.
    task automatic push(input logic [15:0] a, input logic [15:0] c, input logic [47:0] d);
        bit done;
        done = 1'b0;
        @(negedge clk);
        bus_if.cmd_addr  = a;
        bus_if.cmd_chan  = c;
        bus_if.cmd_data  = d;
        bus_if.cmd_valid = 1'b1;
        for (int g = 0; g < 100; g++) begin
            #1;
            if (bus_if.cmd_ready === 1'b1) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("push_accepted", {63'd0, done}, 64'd1);
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            #1;
            if (bus_if.busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        chk("wait_idle", {63'd0, done}, 64'd1);
    endtask

    initial begin
        vec_t tbl[14];
        int   idx;
        int   low;
        logic first_after4;
        bit   seen4;
        bit   found;

        tbl[0]  = mk(1, 1, 16'hAAAA, 16'd1, 48'd5,     0, 0, 16'h0,  16'd0, 48'h0,    0);
        tbl[1]  = mk(1, 1, 16'hAAAA, 16'd1, 48'd5,     0, 0, 16'h0,  16'd0, 48'h0,    0);
        tbl[2]  = mk(0, 0, 16'h0,    16'd0, 48'd0,     1, 0, 16'h0,  16'd0, 48'h0,    0);
        tbl[3]  = mk(0, 1, 16'h0003, 16'd2, 48'h1234,  1, 0, 16'h0,  16'd0, 48'h0,    0);
        tbl[4]  = mk(0, 0, 16'h0,    16'd0, 48'd0,     1, 0, 16'h0,  16'd0, 48'h0,    1);
        tbl[5]  = mk(0, 0, 16'h0,    16'd0, 48'd0,     1, 1, 16'h3,  16'd2, 48'h1234, 1);
        tbl[6]  = mk(0, 0, 16'h0,    16'd0, 48'd0,     1, 0, 16'h3,  16'd2, 48'h1234, 0);
        tbl[7]  = mk(0, 1, 16'h0010, 16'd0, 48'd10,    1, 0, 16'h3,  16'd2, 48'h1234, 0);
        tbl[8]  = mk(0, 1, 16'h0011, 16'd1, 48'd11,    1, 0, 16'h3,  16'd2, 48'h1234, 1);
        tbl[9]  = mk(0, 1, 16'h0012, 16'd2, 48'd12,    1, 1, 16'h10, 16'd0, 48'd10,   1);
        tbl[10] = mk(0, 1, 16'h0013, 16'd3, 48'd13,    1, 1, 16'h11, 16'd1, 48'd11,   1);
        tbl[11] = mk(0, 0, 16'h0,    16'd0, 48'd0,     1, 1, 16'h12, 16'd2, 48'd12,   1);
        tbl[12] = mk(0, 0, 16'h0,    16'd0, 48'd0,     1, 1, 16'h13, 16'd3, 48'd13,   1);
        tbl[13] = mk(0, 0, 16'h0,    16'd0, 48'd0,     1, 0, 16'h13, 16'd3, 48'd13,   0);

        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_addr  = 16'h0;
        bus_if.cmd_chan  = 16'h0;
        bus_if.cmd_data  = 48'h0;
        repeat (2) @(posedge clk);

        // Table: inputs applied on the negedge, outputs of that cycle checked 1 time unit later.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            rst              = tbl[i].rst;
            bus_if.cmd_valid = tbl[i].valid;
            bus_if.cmd_addr  = tbl[i].addr;
            bus_if.cmd_chan  = tbl[i].chan;
            bus_if.cmd_data  = tbl[i].data;
            #1;
            chk($sformatf("v%0d_ready", i), {63'd0, bus_if.cmd_ready}, {63'd0, tbl[i].e_ready});
            chk($sformatf("v%0d_wr_en", i), {63'd0, bus_if.wr_en},     {63'd0, tbl[i].e_en});
            chk($sformatf("v%0d_addr", i),  {48'd0, bus_if.wr_addr},   {48'd0, tbl[i].e_addr});
            chk($sformatf("v%0d_chan", i),  {48'd0, bus_if.wr_chan},   {48'd0, tbl[i].e_chan});
            chk($sformatf("v%0d_data", i),  {16'd0, bus_if.wr_data},   {16'd0, tbl[i].e_data});
            chk($sformatf("v%0d_busy", i),  {63'd0, bus_if.busy},      {63'd0, tbl[i].e_busy});
        end
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;

        // Broadcast followed by a normal command: 9 back-to-back writes.
        wait_idle();
        log_q.delete();
        push(16'h0001, 16'hFFFF, 48'd7);
        push(16'h0002, 16'd5, 48'd9);
        wait_idle();
        chk("bcast_count", 64'(log_q.size()), 64'd9);
        if (log_q.size() == 9) begin
            for (int i = 0; i < 9; i++) begin
                chk($sformatf("bcast_addr%0d", i), {48'd0, log_q[i].addr}, (i < 8) ? 64'h1 : 64'h2);
                chk($sformatf("bcast_chan%0d", i), {48'd0, log_q[i].chan}, (i < 8) ? 64'(i) : 64'd5);
                chk($sformatf("bcast_data%0d", i), {16'd0, log_q[i].data}, (i < 8) ? 64'd7 : 64'd9);
                chk($sformatf("bcast_cyc%0d", i), 64'(log_q[i].cyc - log_q[0].cyc), 64'(i));
            end
        end

        // Backpressure: keep cmd_valid high through a broadcast so the FIFO fills.
        wait_idle();
        log_q.delete();
        @(negedge clk);
        bus_if.cmd_addr  = 16'h0020;
        bus_if.cmd_chan  = 16'hFFFF;
        bus_if.cmd_data  = 48'h77;
        bus_if.cmd_valid = 1'b1;
        #1;
        chk("full_first_ready", {63'd0, bus_if.cmd_ready}, 64'd1);
        idx = 0;
        low = 0;
        seen4 = 1'b0;
        first_after4 = 1'b1;
        for (int g = 0; g < 100 && idx < 5; g++) begin
            @(negedge clk);
            bus_if.cmd_addr  = 16'h0021;
            bus_if.cmd_chan  = 16'd1;
            bus_if.cmd_data  = 48'h100 + 48'(idx);
            bus_if.cmd_valid = 1'b1;
            #1;
            if (idx == 4 && !seen4) begin
                seen4 = 1'b1;
                first_after4 = bus_if.cmd_ready;
            end
            if (bus_if.cmd_ready === 1'b1) begin
                idx++;
            end else begin
                low++;
            end
        end
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        chk("full_accepts", 64'(idx), 64'd5);
        chk("full_ready_after4", {63'd0, first_after4}, 64'd0);
        chk("full_low_cycles", 64'(low), 64'd5);
        wait_idle();
        chk("full_write_count", 64'(log_q.size()), 64'd13);
        if (log_q.size() == 13) begin
            for (int i = 0; i < 13; i++) begin
                chk($sformatf("full_chan%0d", i), {48'd0, log_q[i].chan}, (i < 8) ? 64'(i) : 64'd1);
                chk($sformatf("full_data%0d", i), {16'd0, log_q[i].data},
                    (i < 8) ? 64'h77 : 64'h100 + 64'(i - 8));
                chk($sformatf("full_cyc%0d", i), 64'(log_q[i].cyc - log_q[0].cyc), 64'(i));
            end
        end

        // Reset at broadcast beat 3 with two commands queued.
        wait_idle();
        log_q.delete();
        push(16'h0030, 16'hFFFF, 48'h55);
        push(16'h0031, 16'd2, 48'h66);
        push(16'h0032, 16'd3, 48'h67);
        found = 1'b0;
        for (int g = 0; g < 50; g++) begin
            if (bus_if.wr_en === 1'b1 && bus_if.wr_chan === 16'd3) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_beat3_seen", {63'd0, found}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_wr_en", {63'd0, bus_if.wr_en}, 64'd0);
        chk("rst_busy", {63'd0, bus_if.busy}, 64'd0);
        chk("rst_ready", {63'd0, bus_if.cmd_ready}, 64'd1);
        chk("rst_wr_chan", {48'd0, bus_if.wr_chan}, 64'd0);
        repeat (12) @(negedge clk);
        chk("rst_write_count", 64'(log_q.size()), 64'd4);
        if (log_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rst_chan%0d", i), {48'd0, log_q[i].chan}, 64'(i));
            end
        end
        push(16'h0040, 16'd6, 48'hABC);
        wait_idle();
        chk("post_rst_count", 64'(log_q.size()), 64'd5);
        if (log_q.size() == 5) begin
            chk("post_rst_addr", {48'd0, log_q[4].addr}, 64'h40);
            chk("post_rst_chan", {48'd0, log_q[4].chan}, 64'd6);
            chk("post_rst_data", {16'd0, log_q[4].data}, 64'hABC);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
